countdown_display_core: RTL and testbench

//   Timing/display core for the traffic-signal controller: divides the board clock

---
 rtl/countdown_display_core_pkg.sv | 23 ++
 rtl/countdown_display_core_seg7_decoder.sv | 35 +++
 rtl/countdown_display_core.sv | 63 ++++++
 tb/tb_countdown_display_core.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/countdown_display_core_pkg.sv
// Shared constants for the countdown/display core.
// Holds the active-low 7-segment patterns (bit0=a .. bit6=g, bit7=dp off).
package countdown_display_core_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/countdown_display_core_seg7_decoder.sv
// Hex digit to active-low 7-segment pattern, decimal point always off.
// Latency: purely combinational.
// No flow control; output follows input.
module seg7_decoder
  import countdown_display_core_pkg::*;
(
  input  logic [3:0] value,
  output logic [7:0] seg
);

  // Full 16-entry lookup; the blank default only guards against X inputs.
  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_display_core.sv
// Clock divider producing a one-clk tick, a START..0 down-counter advanced by the tick,
// and a registered 7-segment display of the count (seg lags count by one clk).
// No backpressure: free-running; tick is a clock enable, never a clock.
module countdown_display_core
  import countdown_display_core_pkg::*;
#(
  parameter int unsigned DIV_COUNT = 100_000_000,
  parameter logic [3:0]  START     = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tick,
  output logic [3:0] count,
  output logic       zero,
  output logic [7:0] seg
);

  localparam int unsigned      DIV_W    = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       seg_next;

  // Divider: wrap every DIV_COUNT clks and strobe tick for the clk after the wrap edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // Down-counter: step once per tick; 0 is held a full period and then reloads START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= START;
    end else if (tick) begin
      count <= (count == 4'd0) ? START : count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

  seg7_decoder u_dec (
    .value (count),
    .seg   (seg_next)
  );

  // Display register: keeps the segment drive glitch-free, blank while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
    end else begin
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_countdown_display_core.sv
// Bench for countdown_display_core: three instances (DIV 4/START 9, DIV 4/START 15,
// DIV 1/START 9) sharing clk and rst, checked every clk against an edge-count model,
// plus a vector table and hand sequences for reset and wrap corners.
module tb_countdown_display_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_tick, b_tick, c_tick;
  logic [3:0] a_count, b_count, c_count;
  logic       a_zero, b_zero, c_zero;
  logic [7:0] a_seg, b_seg, c_seg;

  int checks   = 0;
  int failures = 0;
  int n        = 0;   // clk edges since the last reset release

  localparam logic [7:0] SEG_TBL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    int         edge_n;
    logic       tick;
    logic [3:0] count;
    logic       zero;
    logic [7:0] seg;
  } vec_t;

  vec_t tbl[$];

  logic        track_b = 1'b0;
  logic [15:0] b_mask  = '0;
  logic [3:0]  b_prev  = 4'd15;
  logic        b_reload_seen = 1'b0;

  always #5 clk = ~clk;

  countdown_display_core #(.DIV_COUNT(4), .START(4'd9)) dut_a (
    .clk(clk), .rst(rst), .tick(a_tick), .count(a_count), .zero(a_zero), .seg(a_seg));
  countdown_display_core #(.DIV_COUNT(4), .START(4'd15)) dut_b (
    .clk(clk), .rst(rst), .tick(b_tick), .count(b_count), .zero(b_zero), .seg(b_seg));
  countdown_display_core #(.DIV_COUNT(1), .START(4'd9)) dut_c (
    .clk(clk), .rst(rst), .tick(c_tick), .count(c_count), .zero(c_zero), .seg(c_seg));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
    end
  endtask

  // Count value after m edges: ticks seen by edge m are at edges j=1..m-1 with j%D==0.
  function automatic logic [3:0] model_count(int d, int s, int m);
    int k;
    if (m == 0) return 4'(s);
    k = (m - 1) / d;
    return 4'(s - (k % (s + 1)));
  endfunction

  task automatic check_dut(input string nm, input int d, input int s,
                           input logic t, input logic [3:0] c,
                           input logic z, input logic [7:0] sg);
    logic       et;
    logic [3:0] ec;
    logic [7:0] es;
    et = (n >= 1) && ((n % d) == 0);
    ec = model_count(d, s, n);
    es = (n == 0) ? 8'hFF : SEG_TBL[model_count(d, s, n - 1)];
    chk({nm, ".tick"},  {7'd0, t}, {7'd0, et});
    chk({nm, ".count"}, {4'd0, c}, {4'd0, ec});
    chk({nm, ".zero"},  {7'd0, z}, {7'd0, (ec == 4'd0)});
    chk({nm, ".seg"},   sg, es);
  endtask

  task automatic check_all();
    check_dut("A", 4, 9,  a_tick, a_count, a_zero, a_seg);
    check_dut("B", 4, 15, b_tick, b_count, b_zero, b_seg);
    check_dut("C", 1, 9,  c_tick, c_count, c_zero, c_seg);
  endtask

  task automatic check_in_reset(input string nm, input int s, input logic t,
                                input logic [3:0] c, input logic z, input logic [7:0] sg);
    chk({nm, ".rst_tick"},  {7'd0, t}, 8'd0);
    chk({nm, ".rst_count"}, {4'd0, c}, 8'(s));
    chk({nm, ".rst_zero"},  {7'd0, z}, 8'd0);
    chk({nm, ".rst_seg"},   sg, 8'hFF);
  endtask

  task automatic check_all_reset();
    check_in_reset("A", 9,  a_tick, a_count, a_zero, a_seg);
    check_in_reset("B", 15, b_tick, b_count, b_zero, b_seg);
    check_in_reset("C", 9,  c_tick, c_count, c_zero, c_seg);
  endtask

  // One clk: sample 1 time unit after the edge, then compare every instance.
  task automatic step();
    @(posedge clk);
    #1;
    n++;
    check_all();
    if (track_b) begin
      for (int i = 0; i < 16; i++)
        if (b_seg == SEG_TBL[i]) b_mask[i] = 1'b1;
      if (b_prev == 4'd0 && b_count == 4'd15) b_reload_seen = 1'b1;
      b_prev = b_count;
    end
  endtask

  // Pulse reset between edges (called just after a sample), check it acts without a clock.
  task automatic pulse_reset(input int hold);
    #1;
    rst = 1'b1;
    #1;
    check_all_reset();
    #(hold);
    rst = 1'b0;
    n = 0;
  endtask

  initial begin : main
    int tick_cnt, pairs;
    logic prev_tick;

    tbl.push_back('{0,  1'b0, 4'd9, 1'b0, 8'hFF});
    tbl.push_back('{1,  1'b0, 4'd9, 1'b0, 8'h90});
    tbl.push_back('{3,  1'b0, 4'd9, 1'b0, 8'h90});
    tbl.push_back('{4,  1'b1, 4'd9, 1'b0, 8'h90});
    tbl.push_back('{5,  1'b0, 4'd8, 1'b0, 8'h90});
    tbl.push_back('{6,  1'b0, 4'd8, 1'b0, 8'h80});
    tbl.push_back('{8,  1'b1, 4'd8, 1'b0, 8'h80});
    tbl.push_back('{9,  1'b0, 4'd7, 1'b0, 8'h80});
    tbl.push_back('{10, 1'b0, 4'd7, 1'b0, 8'hF8});
    tbl.push_back('{36, 1'b1, 4'd1, 1'b0, 8'hF9});
    tbl.push_back('{37, 1'b0, 4'd0, 1'b1, 8'hF9});
    tbl.push_back('{38, 1'b0, 4'd0, 1'b1, 8'hC0});
    tbl.push_back('{40, 1'b1, 4'd0, 1'b1, 8'hC0});
    tbl.push_back('{41, 1'b0, 4'd9, 1'b0, 8'hC0});
    tbl.push_back('{42, 1'b0, 4'd9, 1'b0, 8'h90});

    // Reset held across several edges.
    #22;
    check_all_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    track_b = 1'b1;
    b_prev = b_count;

    // Vector table for instance A.
    foreach (tbl[i]) begin
      while (n < tbl[i].edge_n) step();
      chk("tbl.tick",  {7'd0, a_tick},  {7'd0, tbl[i].tick});
      chk("tbl.count", {4'd0, a_count}, {4'd0, tbl[i].count});
      chk("tbl.zero",  {7'd0, a_zero},  {7'd0, tbl[i].zero});
      chk("tbl.seg",   a_seg, tbl[i].seg);
    end

    // 40 clks of free run: exactly 10 ticks, never two in a row.
    tick_cnt = 0;
    pairs = 0;
    prev_tick = a_tick;
    for (int i = 0; i < 40; i++) begin
      step();
      if (a_tick) tick_cnt++;
      if (a_tick && prev_tick) pairs++;
      prev_tick = a_tick;
    end
    chk("tick_count_40", 8'(tick_cnt), 8'd10);
    chk("tick_back_to_back", 8'(pairs), 8'd0);

    // START=15 instance has swept more than a full cycle by now.
    track_b = 1'b0;
    chk("B.seg_patterns_lo", b_mask[7:0], 8'hFF);
    chk("B.seg_patterns_hi", b_mask[15:8], 8'hFF);
    chk("B.reload_0_to_15", {7'd0, b_reload_seen}, 8'd1);

    // Mid-count async reset at count=5, div_cnt=2 on instance A.
    pulse_reset(2);
    while (n < 18) step();
    chk("A.pre_rst_count", {4'd0, a_count}, 8'd5);
    pulse_reset(2);
    for (int i = 0; i < 3; i++) step();
    chk("A.restart_no_tick_3", {7'd0, a_tick}, 8'd0);
    step();
    chk("A.restart_tick_4", {7'd0, a_tick}, 8'd1);
    chk("C.count_after_4", {4'd0, c_count}, 8'd6);

    // Randomised run lengths and reset placement against the model.
    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(1, 60);
      for (int i = 0; i < len; i++) step();
      pulse_reset($urandom_range(1, 6));
    end
    for (int i = 0; i < 30; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
